// File: rtl/iagc_sample_accumulator.sv
// Windowed magnitude accumulator for IAGC: averages |sample| over 2^AVG_LOG2 strobes and
// reports the window average, the window peak and the threshold flags at window end.
module iagc_sample_accumulator #(
  parameter int unsigned IAGC_STATUS_SIZE = 4,
  parameter int unsigned DATA_WIDTH       = 12,
  parameter int unsigned AVG_LOG2         = 4
) (
  input  logic                        i_clock,
  input  logic                        i_reset_n,
  input  logic [IAGC_STATUS_SIZE-1:0] i_iagc_status,
  input  logic                        i_gate,
  input  logic                        i_sample,
  input  logic [DATA_WIDTH-1:0]       i_data,
  input  logic [DATA_WIDTH-2:0]       i_thr_high,
  input  logic [DATA_WIDTH-2:0]       i_thr_low,
  output logic [DATA_WIDTH-2:0]       o_avg,
  output logic [DATA_WIDTH-2:0]       o_peak,
  output logic                        o_valid,
  output logic                        o_high,
  output logic                        o_low,
  output logic [AVG_LOG2:0]           o_count
);

  localparam int unsigned MagW = DATA_WIDTH - 1;
  localparam int unsigned AccW = MagW + AVG_LOG2;
  localparam int unsigned CntW = AVG_LOG2 + 1;

  localparam logic [CntW-1:0]             LastCnt   = CntW'((1 << AVG_LOG2) - 1);
  localparam logic [IAGC_STATUS_SIZE-1:0] StatReset = '0;
  localparam logic [IAGC_STATUS_SIZE-1:0] StatInit  = IAGC_STATUS_SIZE'(1);
  localparam logic [DATA_WIDTH-1:0]       MinNeg    = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [AccW-1:0] sum_q, sum_d;
  logic [MagW-1:0] peak_q, peak_d;
  logic [CntW-1:0] count_q, count_d;
  logic [MagW-1:0] avg_q, avg_d;
  logic [MagW-1:0] out_peak_q, out_peak_d;
  logic            valid_q, valid_d;
  logic            high_q, high_d;
  logic            low_q, low_d;

  logic [DATA_WIDTH-1:0] neg_data;
  logic [MagW-1:0]       mag;
  logic [AccW-1:0]       sum_new;
  logic [MagW-1:0]       peak_new;
  logic [MagW-1:0]       avg_new;
  logic                  clear;
  logic                  accept;
  logic                  last;

  // The most-negative code has no positive counterpart, so it saturates.
  always_comb begin
    neg_data = -i_data;
    if (i_data == MinNeg) begin
      mag = '1;
    end else if (i_data[DATA_WIDTH-1]) begin
      mag = neg_data[MagW-1:0];
    end else begin
      mag = i_data[MagW-1:0];
    end
  end

  assign clear    = (i_iagc_status == StatReset) || (i_iagc_status == StatInit) || !i_gate;
  assign accept   = i_sample && !clear;
  assign last     = accept && (count_q == LastCnt);
  assign sum_new  = sum_q + AccW'(mag);
  assign peak_new = (mag > peak_q) ? mag : peak_q;
  assign avg_new  = sum_new[AccW-1:AVG_LOG2];

  always_comb begin
    sum_d      = sum_q;
    peak_d     = peak_q;
    count_d    = count_q;
    avg_d      = avg_q;
    out_peak_d = out_peak_q;
    high_d     = high_q;
    low_d      = low_q;
    valid_d    = 1'b0;
    if (clear) begin
      sum_d   = '0;
      peak_d  = '0;
      count_d = '0;
      if (i_iagc_status == StatReset) begin
        avg_d      = '0;
        out_peak_d = '0;
        high_d     = 1'b0;
        low_d      = 1'b0;
      end
    end else if (last) begin
      sum_d      = '0;
      peak_d     = '0;
      count_d    = '0;
      avg_d      = avg_new;
      out_peak_d = peak_new;
      high_d     = avg_new > i_thr_high;
      low_d      = avg_new < i_thr_low;
      valid_d    = 1'b1;
    end else if (accept) begin
      sum_d   = sum_new;
      peak_d  = peak_new;
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sum_q      <= '0;
      peak_q     <= '0;
      count_q    <= '0;
      avg_q      <= '0;
      out_peak_q <= '0;
      valid_q    <= 1'b0;
      high_q     <= 1'b0;
      low_q      <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      peak_q     <= peak_d;
      count_q    <= count_d;
      avg_q      <= avg_d;
      out_peak_q <= out_peak_d;
      valid_q    <= valid_d;
      high_q     <= high_d;
      low_q      <= low_d;
    end
  end

  assign o_avg   = avg_q;
  assign o_peak  = out_peak_q;
  assign o_valid = valid_q;
  assign o_high  = high_q;
  assign o_low   = low_q;
  assign o_count = count_q;

endmodule

// File: tb/tb_iagc_sample_accumulator.sv
// Directed bench for iagc_sample_accumulator: windows, saturation, gate/status clears, async reset.
module tb_iagc_sample_accumulator;

  logic        clk;
  logic        rst_n;
  logic [3:0]  status;
  logic        gate;
  logic        sample;
  logic [11:0] data;
  logic [10:0] thr_high;
  logic [10:0] thr_low;
  logic [10:0] avg;
  logic [10:0] peak;
  logic        valid;
  logic        high;
  logic        low;
  logic [4:0]  count;

  int tests;
  int fails;

  iagc_sample_accumulator #(
    .IAGC_STATUS_SIZE(4),
    .DATA_WIDTH      (12),
    .AVG_LOG2        (4)
  ) dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_iagc_status(status),
    .i_gate       (gate),
    .i_sample     (sample),
    .i_data       (data),
    .i_thr_high   (thr_high),
    .i_thr_low    (thr_low),
    .o_avg        (avg),
    .o_peak       (peak),
    .o_valid      (valid),
    .o_high       (high),
    .o_low        (low),
    .o_count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs read there are settled from the prior rising edge.
  task automatic step(input logic s, input logic [11:0] d);
    @(negedge clk);
    sample = s;
    data   = d;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    status   = 4'b0010;
    gate     = 1'b1;
    sample   = 1'b0;
    data     = '0;
    thr_high = 11'd200;
    thr_low  = 11'd50;
    #23;
    tests++;
    if ({avg, peak, valid, high, low, count} !== '0) begin
      fails++;
      $display("FAIL reset_hold outputs=%h required 0", {avg, peak, valid, high, low, count});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0);
    step(1'b0, '0);
    tests++;
    if ({avg, peak, valid, high, low} !== '0) begin
      fails++;
      $display("FAIL reset_release outputs=%h required 0", {avg, peak, valid, high, low});
    end
    tests++;
    if (count !== 5'd0) begin
      fails++;
      $display("FAIL reset_count got %0d required 0", count);
    end
  endtask

  task automatic test_constant_window;
    for (int i = 0; i < 16; i++) step(1'b1, 12'd100);
    tests++;
    if (count !== 5'd15) begin
      fails++;
      $display("FAIL const_count15 got %0d required 15", count);
    end
    step(1'b0, '0);
    tests++;
    if (valid !== 1'b1 || avg !== 11'd100 || peak !== 11'd100 || high !== 1'b0 || low !== 1'b0) begin
      fails++;
      $display("FAIL const_window v=%b avg=%0d peak=%0d h=%b l=%b required 1 100 100 0 0",
               valid, avg, peak, high, low);
    end
    tests++;
    if (count !== 5'd0) begin
      fails++;
      $display("FAIL const_count_wrap got %0d required 0", count);
    end
    step(1'b0, '0);
    tests++;
    if (valid !== 1'b0) begin
      fails++;
      $display("FAIL const_valid_pulse got %b required 0", valid);
    end
  endtask

  task automatic test_saturation;
    thr_high = 11'd1023;
    thr_low  = 11'd1023;
    for (int i = 0; i < 16; i++) step(1'b1, (i % 2 == 0) ? 12'h800 : 12'h000);
    step(1'b0, '0);
    tests++;
    if (valid !== 1'b1 || avg !== 11'd1023 || peak !== 11'd2047) begin
      fails++;
      $display("FAIL sat_window v=%b avg=%0d peak=%0d required 1 1023 2047", valid, avg, peak);
    end
    tests++;
    if (high !== 1'b0 || low !== 1'b0) begin
      fails++;
      $display("FAIL sat_thr_equal h=%b l=%b required 0 0", high, low);
    end
  endtask

  task automatic test_gate_drop;
    logic early_valid;
    thr_high = 11'd200;
    thr_low  = 11'd50;
    for (int i = 0; i < 7; i++) step(1'b1, 12'd100);
    step(1'b1, 12'd100);
    gate = 1'b0;
    step(1'b0, '0);
    gate = 1'b1;
    tests++;
    if (valid !== 1'b0 || avg !== 11'd1023 || count !== 5'd0) begin
      fails++;
      $display("FAIL gate_drop v=%b avg=%0d cnt=%0d required 0 1023 0", valid, avg, count);
    end
    early_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 12'd40);
      if (valid) early_valid = 1'b1;
    end
    tests++;
    if (early_valid !== 1'b0) begin
      fails++;
      $display("FAIL gate_partial_valid got %b required 0", early_valid);
    end
    step(1'b0, '0);
    tests++;
    if (valid !== 1'b1 || avg !== 11'd40 || peak !== 11'd40 || high !== 1'b0 || low !== 1'b1) begin
      fails++;
      $display("FAIL gate_window v=%b avg=%0d peak=%0d h=%b l=%b required 1 40 40 0 1",
               valid, avg, peak, high, low);
    end
  endtask

  task automatic test_status_clear;
    for (int i = 0; i < 15; i++) step(1'b1, 12'd30);
    step(1'b1, 12'd30);
    status = 4'b0001;
    step(1'b0, '0);
    tests++;
    if (valid !== 1'b0 || count !== 5'd0 || avg !== 11'd40 || peak !== 11'd40) begin
      fails++;
      $display("FAIL init_clear v=%b cnt=%0d avg=%0d peak=%0d required 0 0 40 40",
               valid, count, avg, peak);
    end
    status = 4'b0000;
    step(1'b0, '0);
    status = 4'b0010;
    tests++;
    if (avg !== 11'd0 || peak !== 11'd0 || low !== 1'b0 || valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_status avg=%0d peak=%0d l=%b v=%b required 0 0 0 0",
               avg, peak, low, valid);
    end
  endtask

  task automatic test_async_reset;
    thr_high = 11'd66;
    thr_low  = 11'd70;
    for (int i = 0; i < 9; i++) step(1'b1, 12'd50);
    step(1'b0, '0);
    tests++;
    if (count !== 5'd9) begin
      fails++;
      $display("FAIL async_pre_count got %0d required 9", count);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (count !== 5'd0) begin
      fails++;
      $display("FAIL async_count got %0d required 0", count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        step(1'b0, '0);
        step(1'b0, '0);
        step(1'b0, '0);
        tests++;
        if (count !== 5'd8) begin
          fails++;
          $display("FAIL idle_hold_count got %0d required 8", count);
        end
      end
      step(1'b1, (i % 2 == 0) ? 12'(60 + i) : 12'(-(60 + i)));
    end
    step(1'b0, '0);
    tests++;
    if (valid !== 1'b1 || avg !== 11'd67 || peak !== 11'd75) begin
      fails++;
      $display("FAIL async_window v=%b avg=%0d peak=%0d required 1 67 75", valid, avg, peak);
    end
    tests++;
    if (high !== 1'b1 || low !== 1'b1) begin
      fails++;
      $display("FAIL both_flags h=%b l=%b required 1 1", high, low);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_constant_window();
    test_saturation();
    test_gate_drop();
    test_status_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
